// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//
// Responder end of the CPU data-SRAM interface. Serves loads and stores from an
// on-chip word-addressed RAM with byte-lane write enables, and decodes a small
// MMIO window (LED register, free-running cycle counter, scratch register).
// There is no stall path, so every access completes with fixed latency:
// writes land on the accepting edge, and read data is valid after that edge.
//
// Ports
//   clk              system clock, all state updates on the rising edge
//   resetn           asynchronous active-low reset
//   data_sram_en     access request this cycle
//   data_sram_wen    byte write enables (4'b0000 with en=1 is a read)
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  lane-aligned store data
//   data_sram_rdata  registered load data, holds until the next read
//   led              LED register contents
// -----------------------------------------------------------------------------
module data_sram_resp #(
  parameter int          ADDR_BITS = 12,
  parameter logic [15:0] MMIO_HI   = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // MMIO register offsets, expressed as word offsets (addr[15:2]).
  localparam logic [13:0] OFF_LED = 14'd0;
  localparam logic [13:0] OFF_CNT = 14'd1;
  localparam logic [13:0] OFF_SCR = 14'd2;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic                 w_mmio;
  logic                 w_is_wr;
  logic [ADDR_BITS-1:0] w_idx;
  logic [13:0]          w_off;
  logic                 w_ram_wr;
  logic                 w_ram_rd;
  logic                 w_mmio_wr;
  logic                 w_mmio_rd;
  logic                 w_unused;

  assign w_mmio    = (data_sram_addr[31:16] == MMIO_HI);
  assign w_is_wr   = |data_sram_wen;
  // Upper address bits are dropped, so RAM addresses alias modulo the depth.
  assign w_idx     = data_sram_addr[ADDR_BITS+1:2];
  assign w_off     = data_sram_addr[15:2];
  assign w_ram_wr  = data_sram_en & ~w_mmio &  w_is_wr;
  assign w_ram_rd  = data_sram_en & ~w_mmio & ~w_is_wr;
  assign w_mmio_wr = data_sram_en &  w_mmio &  w_is_wr;
  assign w_mmio_rd = data_sram_en &  w_mmio & ~w_is_wr;
  assign w_unused  = ^data_sram_addr[1:0];

  // Byte-lane merge of new data into an existing word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // RAM: single port, byte-lane writes, registered read port
  // ---------------------------------------------------------------------------
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_ram_q;

  // NOTE: the array and its output register have no reset so the tools can map
  // them onto a block RAM; resetn only gates the enables so an edge seen while
  // reset is asserted cannot disturb stored data.
  always_ff @(posedge clk) begin
    if (resetn && w_ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
    // Only a RAM read updates the output register, so it holds otherwise.
    if (resetn && w_ram_rd) r_ram_q <= r_mem[w_idx];
  end

  // ---------------------------------------------------------------------------
  // MMIO registers and read path
  // ---------------------------------------------------------------------------
  logic [15:0] r_led;
  logic [31:0] r_scratch;
  logic [31:0] r_counter;
  logic [31:0] w_counter_nxt;
  logic [31:0] r_mmio_q;
  logic        r_rd_ram;     // last accepted read came from RAM
  logic [31:0] w_mmio_rdata;

  assign w_counter_nxt = r_counter + 32'd1;  // wraps naturally at 2^32

  // NOTE: every path assigns w_mmio_rdata a default first, so no latch forms.
  always_comb begin
    w_mmio_rdata = 32'h0000_0000;
    case (w_off)
      OFF_LED: w_mmio_rdata = {16'h0000, r_led};
      OFF_CNT: w_mmio_rdata = r_counter;     // pre-increment value of this edge
      OFF_SCR: w_mmio_rdata = r_scratch;
      default: w_mmio_rdata = 32'h0000_0000;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, which is what gives the counter read its
  // pre-increment result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_led     <= 16'h0000;
      r_scratch <= 32'h0000_0000;
      r_counter <= 32'h0000_0000;
      r_mmio_q  <= 32'h0000_0000;
      r_rd_ram  <= 1'b0;
    end else begin
      r_counter <= w_counter_nxt;

      if (w_mmio_wr) begin
        case (w_off)
          // LED only has lanes 0-1; upper enables are ignored.
          OFF_LED: r_led     <= lane_merge({16'h0000, r_led}, data_sram_wdata,
                                           {2'b00, data_sram_wen[1:0]})[15:0];
          OFF_SCR: r_scratch <= lane_merge(r_scratch, data_sram_wdata, data_sram_wen);
          default: ;  // counter and unmapped offsets ignore writes
        endcase
      end

      if (w_mmio_rd) begin
        r_mmio_q <= w_mmio_rdata;
        r_rd_ram <= 1'b0;
      end else if (w_ram_rd) begin
        r_rd_ram <= 1'b1;
      end
    end
  end

  // During reset r_rd_ram=0 and r_mmio_q=0, so rdata clears without a clock.
  assign data_sram_rdata = r_rd_ram ? r_ram_q : r_mmio_q;
  assign led             = r_led;

endmodule

// File: tb/tb_data_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_resp
//
// Directed bench for data_sram_resp. A transaction-level model (word map, LED,
// scratch, counter) is advanced once per accepted edge and compared with the
// DUT on every falling edge; literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;

  data_sram_resp dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata = 32'h0;
  logic [15:0] m_led   = 16'h0;
  logic [31:0] m_scr   = 32'h0;
  logic [31:0] m_cnt   = 32'h0;
  logic        force_m = 1'b0;

  // Inputs as seen at the last rising edge.
  logic        s_valid = 1'b0;
  logic        s_en    = 1'b0;
  logic        s_force = 1'b0;
  logic [3:0]  s_wen   = 4'h0;
  logic [31:0] s_addr  = 32'h0;
  logic [31:0] s_wdata = 32'h0;

  always @(posedge clk) begin
    s_valid <= resetn;
    s_en    <= data_sram_en;
    s_wen   <= data_sram_wen;
    s_addr  <= data_sram_addr;
    s_wdata <= data_sram_wdata;
    s_force <= force_m;
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      m_rdata = 32'h0; m_led = 16'h0; m_scr = 32'h0; m_cnt = 32'h0;
    end else if (s_valid) begin
      if (s_en) begin
        if (s_addr[31:16] == 16'hBFAF) begin
          int off;
          off = int'(s_addr[15:0]) / 4;
          if (s_wen != 4'h0) begin
            if (off == 0) begin
              if (s_wen[0]) m_led[7:0]  = s_wdata[7:0];
              if (s_wen[1]) m_led[15:8] = s_wdata[15:8];
            end else if (off == 2) begin
              m_scr = merge(m_scr, s_wdata, s_wen);
            end
          end else begin
            if (off == 0)      m_rdata = {16'h0, m_led};
            else if (off == 1) m_rdata = m_cnt;
            else if (off == 2) m_rdata = m_scr;
            else               m_rdata = 32'h0;
          end
        end else begin
          int idx;
          idx = int'(s_addr % 32'h4000) / 4;  // 4096 words of 4 bytes
          if (s_wen != 4'h0) begin
            if (!m_mem.exists(idx)) m_mem[idx] = 32'h0;
            m_mem[idx] = merge(m_mem[idx], s_wdata, s_wen);
          end else begin
            m_rdata = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
          end
        end
      end
      m_cnt = s_force ? 32'hFFFF_FFFF : m_cnt + 32'd1;
    end
    check("model_rdata",   data_sram_rdata, m_rdata);
    check("model_led",     {16'h0, led},    {16'h0, m_led});
    check("model_counter", dut.r_counter,   m_cnt);
    check("model_scratch", dut.r_scratch,   m_scr);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata);
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
  endtask

  task automatic rd(input logic [31:0] addr);
    access(4'h0, addr, 32'h0);
  endtask

  initial begin
    #2 resetn = 1'b0;
    #1;
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led",   {16'h0, led},    32'h0);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;

    // Counter: read presented at the 10th edge after release returns 9.
    repeat (9) @(posedge clk);
    #1;
    rd(32'hBFAF_0004); check("cnt_edge10", data_sram_rdata, 32'd9);
    rd(32'hBFAF_0004); check("cnt_b2b_1",  data_sram_rdata, 32'd10);
    rd(32'hBFAF_0004); check("cnt_b2b_2",  data_sram_rdata, 32'd11);

    // Full word store then load.
    access(4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010); check("ram_full", data_sram_rdata, 32'hDEAD_BEEF);

    // Byte-lane merge, then wen=0 is a read and leaves contents alone.
    access(4'b0100, 32'h0000_0010, 32'h00AA_0000);
    rd(32'h0000_0010); check("ram_lane", data_sram_rdata, 32'hDEAA_BEEF);
    access(4'h0, 32'h0000_0010, 32'hFFFF_FFFF);
    check("ram_wen0_is_read", data_sram_rdata, 32'hDEAA_BEEF);
    rd(32'h0000_0013); check("ram_wen0_unchanged", data_sram_rdata, 32'hDEAA_BEEF);

    // Aliasing modulo 16 KB.
    access(4'hF, 32'h0000_4010, 32'h1234_5678);
    rd(32'h0000_0010); check("ram_alias", data_sram_rdata, 32'h1234_5678);
    access(4'hF, 32'h0000_0020, 32'hCAFE_F00D);
    access(4'hF, 32'h0000_3FFC, 32'hA5A5_0001);
    rd(32'hFFFF_FFFC); check("ram_top_alias", data_sram_rdata, 32'hA5A5_0001);

    // LED register.
    access(4'hF, 32'hBFAF_0000, 32'hFFFF_5A5A);
    check("led_write", {16'h0, led}, 32'h0000_5A5A);
    rd(32'hBFAF_0000); check("led_read", data_sram_rdata, 32'h0000_5A5A);
    access(4'b1100, 32'hBFAF_0000, 32'h1234_0000);
    check("led_upper_ignored", {16'h0, led}, 32'h0000_5A5A);
    access(4'b0001, 32'hBFAF_0000, 32'h0000_00C3);
    check("led_lane0", {16'h0, led}, 32'h0000_5AC3);

    // Counter writes are ignored (model tracks the exact value).
    access(4'hF, 32'hBFAF_0004, 32'h0000_0000);
    rd(32'hBFAF_0004);

    // Scratch with byte lanes.
    access(4'hF, 32'hBFAF_0008, 32'h1122_3344);
    access(4'b0010, 32'hBFAF_0008, 32'h0000_AB00);
    rd(32'hBFAF_0008); check("scratch", data_sram_rdata, 32'h1122_AB44);

    // rdata holds across writes and idle cycles.
    access(4'hF, 32'h0000_0030, 32'h5555_AAAA);
    repeat (3) @(posedge clk);
    #1 check("rdata_hold", data_sram_rdata, 32'h1122_AB44);

    // Unmapped MMIO offsets.
    access(4'hF, 32'hBFAF_0040, 32'hFFFF_FFFF);
    rd(32'hBFAF_0040); check("mmio_unmapped", data_sram_rdata, 32'h0);
    rd(32'hBFAF_0008); check("scratch_kept", data_sram_rdata, 32'h1122_AB44);
    rd(32'hBFAF_000C); check("mmio_unmapped_c", data_sram_rdata, 32'h0);

    // Counter wrap: load all-ones for one edge.
    @(negedge clk);
    force dut.w_counter_nxt = 32'hFFFF_FFFF;
    force_m = 1'b1;
    @(negedge clk);
    release dut.w_counter_nxt;
    force_m = 1'b0;
    #1;
    rd(32'hBFAF_0004); check("cnt_all_ones", data_sram_rdata, 32'hFFFF_FFFF);
    rd(32'hBFAF_0004); check("cnt_wrap",     data_sram_rdata, 32'h0000_0000);

    // Reset mid-write.
    rd(32'h0000_0020); check("pre_reset_rd", data_sram_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    #1;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = 32'h0000_0020;
    data_sram_wdata = 32'h0BAD_BAD0;
    #1 resetn = 1'b0;
    #1;
    check("async_rdata",   data_sram_rdata, 32'h0);
    check("async_led",     {16'h0, led},    32'h0);
    check("async_counter", dut.r_counter,   32'h0);
    check("async_scratch", dut.r_scratch,   32'h0);
    @(posedge clk);
    #1;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
    @(negedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    rd(32'h0000_0020); check("post_reset_ram",  data_sram_rdata, 32'hCAFE_F00D);
    rd(32'h0000_0010); check("post_reset_ram2", data_sram_rdata, 32'h1234_5678);
    rd(32'hBFAF_0008); check("post_reset_scr",  data_sram_rdata, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder end of the CPU data-SRAM interface (en / wen / addr / wdata / rdata).
- Serves CPU loads and stores from an on-chip word-addressed RAM with byte-lane write enables.
- Decodes a small MMIO window containing an LED register, a free-running cycle counter and a scratch register.
- Sits in the SoC top between the cpu data port and the board LEDs; no stall signal exists, so all latencies are fixed.

Parameters:
- ADDR_BITS, 12, word-index width of the RAM (depth = 2^ADDR_BITS words, 16 KB at default).
- MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window instead of RAM.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- data_sram_en  input  1  access request this cycle.
- data_sram_wen  input  4  byte write enables; bit i covers wdata[8i+7:8i]; 4'b0000 with en=1 is a read.
- data_sram_addr  input  32  byte address; bits [1:0] ignored.
- data_sram_wdata  input  32  store data, already lane-aligned by the CPU.
- data_sram_rdata  output  32  registered load data.
- led  output  16  LED register contents.

Behaviour:
- Reset is asynchronous and active-low, clocked by clk.
  - While resetn=0: rdata=0, led=0, counter=0, scratch=0.
  - RAM contents are not reset.
  - Reset asserted mid-access discards that access; no RAM write occurs on an edge where resetn=0.
- Decode:
  - mmio = (addr[31:16] == MMIO_HI).
  - Otherwise the access targets RAM word addr[ADDR_BITS+1:2].
  - Upper address bits are ignored for RAM, so addresses alias modulo the RAM size.
- Write (en=1, wen!=0):
  - On the rising edge, only the enabled byte lanes of the target are updated.
  - rdata holds its previous value.
- Read (en=1, wen=0):
  - Target sampled at the rising edge; rdata is valid after that edge (1-cycle latency).
  - rdata holds until the next read is accepted.
- Idle (en=0): no state change except the counter; rdata holds.
- Read-after-write to the same word on consecutive cycles returns the newly written data (no hazard).
- Single port: one access per cycle. The RAM must infer as block RAM with a registered output.
- MMIO offsets (addr[15:0]):
  - 0x0000 LED:
    - Read returns {16'b0, led}.
    - Write uses lanes 0–1 only; wen[3:2] ignored.
  - 0x0004 COUNTER:
    - Read-only; writes ignored.
    - 32-bit counter increments every cycle out of reset and wraps 0xFFFFFFFF -> 0x00000000.
    - A read at an edge returns the pre-increment value from that same edge.
  - 0x0008 SCRATCH: 32-bit read/write with full byte-lane enables.
  - Any other offset: reads return 0x00000000, writes ignored, no error signalled.
- Simultaneous events: a counter increment and a counter read on the same edge follow the pre-increment rule above. No other simultaneous-source cases exist.

Test Plan:
- Full-word store then load: write addr 0x00000010, wen=4'hF, wdata=0xDEADBEEF; next cycle read 0x10 -> rdata=0xDEADBEEF one cycle after the read edge.
- Byte-lane merge: after the above, write 0x10 with wen=4'b0100, wdata=0x00AA0000; read -> 0xDEAABEEF. Then write wen=0 is a read, not a write; contents unchanged.
- Aliasing / wrap: write 0x00004010 (ADDR_BITS=12) with 0x12345678; read 0x00000010 -> 0x12345678.
- MMIO:
  - Write LED 0xBFAF0000 with wen=4'hF, wdata=0xFFFF5A5A -> led=0x5A5A; read -> 0x00005A5A.
  - Write COUNTER -> value unaffected.
  - Read 0xBFAF0040 -> 0.
- Counter: release reset and read 0xBFAF0004 at the 10th edge after release -> 9. Back-to-back reads return consecutive values N, N+1. Force counter to 0xFFFFFFFF (hierarchical force) -> next read 0x00000000.
- Reset mid-operation:
  - Assert resetn=0 asynchronously while a write is presented -> RAM word unchanged, and rdata, led, counter and scratch are 0 immediately without waiting for a clock.
  - After release, the first read returns pre-existing RAM data.
